ripple_count_sampler: RTL and testbench
=======================================

Name: ripple_count_sampler

Overview:
Consumes the asynchronous, rippling Q bus of a ripple counter and produces a clean, clk-domain snapshot on request. It uses a two-flop synchronizer and a stability filter, because ripple outputs glitch through intermediate codes. It also computes a modular delta against the previously delivered snapshot. Results leave through a valid/ready handshake to downstream logic, such as a rate monitor or a register file.

Parameters:
COUNTER_WIDTH, 4, width of the counter bus being sampled.
STABLE_CYCLES, 2, number of consecutive equal synchronized samples required before capture (>=1).
MAX_WAIT, 16, maximum cycles spent settling before a forced capture (> STABLE_CYCLES).

Ports:
clk  input  1  system clock; all state rises on posedge.
resetn  input  1  asynchronous, active-low reset.
cnt_in  input  COUNTER_WIDTH  raw ripple counter value, asynchronous to clk.
sample_req  input  1  request a snapshot; honoured only in IDLE.
out_ready  input  1  downstream accepts the snapshot.
cnt_valid  output  1  snapshot outputs are valid.
cnt_out  output  COUNTER_WIDTH  captured counter value.
delta_out  output  COUNTER_WIDTH  cnt_out minus last accepted value, mod 2^COUNTER_WIDTH.
wrap_flag  output  1  cnt_out < last accepted value (counter wrapped).
timeout_flag  output  1  capture was forced by MAX_WAIT, not by stability.
busy  output  1  state != IDLE.

Behaviour:
- Reset, asynchronous on resetn low:
  - State goes to IDLE.
  - Synchronizer flops, the previous-sample register, stab_cnt, wait_cnt, last_ref, cnt_out and delta_out all clear to 0.
  - cnt_valid, wrap_flag, timeout_flag and busy clear to 0.
  - Reset mid-SETTLE or mid-PRESENT aborts the operation; the snapshot is lost.
- Synchronizer:
  - sync1 <= cnt_in and sync2 <= sync1 every cycle, in every state.
  - prev <= sync2 every cycle.
  - match = (sync2 == prev).
- FSM states are IDLE, SETTLE and PRESENT.
- IDLE:
  - When sample_req = 1, go to SETTLE, with stab_cnt = 0 and wait_cnt = 0.
  - When sample_req = 0, stay in IDLE.
- SETTLE, evaluated at each edge:
  - wait_cnt increments.
  - On match, stab_cnt increments; otherwise stab_cnt is cleared to 0.
  - If match and stab_cnt+1 == STABLE_CYCLES: capture cnt_out <= sync2, set timeout_flag <= 0, go to PRESENT.
  - Else if wait_cnt+1 == MAX_WAIT: capture cnt_out <= sync2, set timeout_flag <= 1, go to PRESENT.
  - If both conditions are true on the same edge, the stability capture wins (timeout_flag = 0).
  - Latency with a steady input: cnt_valid rises exactly STABLE_CYCLES edges after the edge that sampled sample_req.
- Capture also registers:
  - delta_out <= sync2 - last_ref, truncated to COUNTER_WIDTH.
  - wrap_flag <= (sync2 < last_ref).
  - cnt_valid <= 1.
- PRESENT:
  - cnt_valid is held at 1.
  - cnt_out, delta_out, wrap_flag and timeout_flag are held stable until transfer.
  - Transfer occurs at the edge where cnt_valid & out_ready. At that edge: last_ref <= cnt_out, cnt_valid <= 0, state goes to IDLE.
  - The data outputs keep their last values after transfer.
  - out_ready may already be high when cnt_valid rises; transfer then occurs on the next edge.
- sample_req handling:
  - sample_req is ignored while busy, including during the transfer cycle; no queuing.
  - The minimum request spacing is therefore STABLE_CYCLES+2 cycles.
- Equal values: cnt_out == last_ref gives delta_out = 0 and wrap_flag = 0.
- First snapshot after reset: delta is taken against last_ref = 0.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset, then cnt_in=4'h5 held steady; pulse sample_req at edge E0 with out_ready=1 -> cnt_valid rises after E0+2; cnt_out=5, delta_out=5, wrap_flag=0, timeout_flag=0; busy drops after the transfer edge.
- Deliver a snapshot of 4'hE (last_ref=E), then hold cnt_in=4'h3 and request again -> cnt_out=3, delta_out=4'h5, wrap_flag=1.
- Toggle cnt_in between 4'h7 and 4'h8 every cycle for 30 cycles and request -> capture at the 16th SETTLE edge, timeout_flag=1, cnt_out equal to sync2 at that edge (7 or 8).
- Hold out_ready=0 for 10 cycles after cnt_valid while changing cnt_in and pulsing sample_req -> outputs stay frozen, and no second capture occurs; release out_ready -> exactly one transfer.
- Assert resetn=0 mid-SETTLE and mid-PRESENT -> all outputs read 0 immediately (asynchronously); the next request after reset delivers a delta against 0.
- STABLE_CYCLES=1 build with a steady input -> cnt_valid rises one edge after the request edge.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
// Takes a snapshot of an asynchronous ripple-counter bus and delivers it in
// the clk domain. A two-flop synchronizer feeds a stability filter, because
// the ripple bus passes through intermediate codes while it changes. Each
// snapshot also carries its modular distance from the previously delivered
// snapshot.
//
// Ports:
//   clk          system clock, all state on posedge
//   resetn       asynchronous active-low reset
//   cnt_in       raw ripple counter bus (asynchronous to clk)
//   sample_req   request a snapshot (only honoured while idle)
//   out_ready    downstream accepts the presented snapshot
//   cnt_valid    snapshot outputs are valid
//   cnt_out      captured counter value
//   delta_out    cnt_out - last accepted value, mod 2^COUNTER_WIDTH
//   wrap_flag    cnt_out < last accepted value
//   timeout_flag capture was forced after MAX_WAIT settling cycles
//   busy         a snapshot is settling or being presented
module ripple_count_sampler #(
  parameter int COUNTER_WIDTH = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_WAIT      = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [COUNTER_WIDTH-1:0] cnt_in,
  input  logic                     sample_req,
  input  logic                     out_ready,
  output logic                     cnt_valid,
  output logic [COUNTER_WIDTH-1:0] cnt_out,
  output logic [COUNTER_WIDTH-1:0] delta_out,
  output logic                     wrap_flag,
  output logic                     timeout_flag,
  output logic                     busy
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  // Comparing the current count against N-1 is the same as checking cnt+1 == N.
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [COUNTER_WIDTH-1:0] r_sync1;
  logic [COUNTER_WIDTH-1:0] r_sync2;
  logic [COUNTER_WIDTH-1:0] r_prev;
  logic [COUNTER_WIDTH-1:0] r_last_ref;
  logic [SW-1:0]            r_stab_cnt;
  logic [WW-1:0]            r_wait_cnt;

  logic                     r_cnt_valid;
  logic [COUNTER_WIDTH-1:0] r_cnt_out;
  logic [COUNTER_WIDTH-1:0] r_delta_out;
  logic                     r_wrap_flag;
  logic                     r_timeout_flag;
  logic                     r_busy;

  logic                     w_match;
  logic                     w_capture;
  logic                     w_cap_timeout;
  logic                     w_transfer;

  // Modular distance; the subtraction simply truncates to the bus width.
  function automatic logic [COUNTER_WIDTH-1:0] f_mod_delta(
    input logic [COUNTER_WIDTH-1:0] a,
    input logic [COUNTER_WIDTH-1:0] b
  );
    return a - b;
  endfunction

  assign w_match = (r_sync2 == r_prev);

  // Synchronizer stage and one-sample history for the stability filter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= cnt_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_cap_timeout = 1'b0;
    w_transfer    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_req) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Stability is tested first so it wins when both fire together.
        if (w_match && (r_stab_cnt == STAB_LAST)) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_capture     = 1'b1;
          w_cap_timeout = 1'b1;
          w_state_nxt   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // cnt_valid is always high in PRESENT, so out_ready alone completes it.
        if (out_ready) begin
          w_transfer  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Settling counters: held at zero outside SETTLE, so every entry starts clean
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stab_cnt <= '0;
      r_wait_cnt <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      r_stab_cnt <= w_match ? (r_stab_cnt + 1'b1) : '0;
    end else begin
      r_stab_cnt <= '0;
      r_wait_cnt <= '0;
    end
  end

  // Capture / present stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt_valid    <= 1'b0;
      r_cnt_out      <= '0;
      r_delta_out    <= '0;
      r_wrap_flag    <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_last_ref     <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_capture) begin
        r_cnt_valid    <= 1'b1;
        r_cnt_out      <= r_sync2;
        r_delta_out    <= f_mod_delta(r_sync2, r_last_ref);
        r_wrap_flag    <= (r_sync2 < r_last_ref);
        r_timeout_flag <= w_cap_timeout;
      end else if (w_transfer) begin
        r_cnt_valid <= 1'b0;
        r_last_ref  <= r_cnt_out;
      end
    end
  end

  assign cnt_valid    = r_cnt_valid;
  assign cnt_out      = r_cnt_out;
  assign delta_out    = r_delta_out;
  assign wrap_flag    = r_wrap_flag;
  assign timeout_flag = r_timeout_flag;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Scoreboard bench for ripple_count_sampler: the driver predicts each
// snapshot from the counter values it plays, a monitor checks what the DUT
// presents. A second instance with STABLE_CYCLES=1 checks the short latency.
module tb_ripple_count_sampler;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int MW = 16;
  localparam int L  = MW + 14;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic         sample_req = 1'b0;
  logic         out_ready = 1'b0;

  logic         cnt_valid, wrap_flag, timeout_flag, busy;
  logic [W-1:0] cnt_out, delta_out;
  logic         d1_valid, d1_wrap, d1_tmo, d1_busy;
  logic [W-1:0] d1_cnt, d1_delta;

  ripple_count_sampler #(.COUNTER_WIDTH(W), .STABLE_CYCLES(S), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .resetn(resetn), .cnt_in(cnt_in), .sample_req(sample_req),
    .out_ready(out_ready), .cnt_valid(cnt_valid), .cnt_out(cnt_out),
    .delta_out(delta_out), .wrap_flag(wrap_flag), .timeout_flag(timeout_flag),
    .busy(busy));

  ripple_count_sampler #(.COUNTER_WIDTH(W), .STABLE_CYCLES(1), .MAX_WAIT(MW)) u_dut1 (
    .clk(clk), .resetn(resetn), .cnt_in(cnt_in), .sample_req(sample_req),
    .out_ready(out_ready), .cnt_valid(d1_valid), .cnt_out(d1_cnt),
    .delta_out(d1_delta), .wrap_flag(d1_wrap), .timeout_flag(d1_tmo),
    .busy(d1_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] delta;
    logic         wrap;
    logic         tmo;
    int           cap_e;
    int           xfer_e;
  } exp_t;

  exp_t         q[$];
  exp_t         cur;
  bit           have_cur = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] h [0:8191];
  logic [W-1:0] plan [0:L-1];
  int           tx_r = 0;
  logic [W-1:0] model_ref = '0;
  int           d1_rise = -1;
  logic [W-1:0] d1_rise_cnt = '0;

  // Value the synchronizer input saw at each edge (0 while held in reset).
  always @(posedge clk) begin
    cyc = cyc + 1;
    h[cyc] = resetn ? cnt_in : '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] hv(input int k);
    return (k >= tx_r) ? plan[k - tx_r] : h[k];
  endfunction

  // Drive one request. kind: 0 steady a, 1 toggle a/b, 2 random glitches then a,
  // 3 random every cycle, 4 steady a for MW cycles then random.
  // rst_at >= 0 pulses reset at that cycle; -2 pulses it just after capture.
  task automatic do_txn(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int rdy_start, input int rst_at, input bit pokes);
    int   c, t, rj, g;
    bit   tmo, ok;
    logic [W-1:0] v;
    exp_t e;
    g = $urandom_range(0, MW);
    for (int j = 0; j < L; j++) begin
      case (kind)
        0:       plan[j] = a;
        1:       plan[j] = (j % 2 == 0) ? a : b;
        2:       plan[j] = (j < g) ? W'($urandom) : a;
        3:       plan[j] = W'($urandom);
        default: plan[j] = (j < MW) ? a : W'($urandom);
      endcase
    end
    tx_r = cyc + 1;
    // Capture happens at the first edge whose last S+1 synchronized samples
    // (all taken since the request) agree; otherwise at edge R+MW.
    c = -1;
    tmo = 1'b1;
    for (int ed = tx_r + S; ed <= tx_r + MW && c < 0; ed++) begin
      ok = 1'b1;
      for (int k = ed - 2 - S; k < ed - 2; k++)
        if (hv(k) != hv(k + 1)) ok = 1'b0;
      if (ok) begin
        c = ed;
        tmo = 1'b0;
      end
    end
    if (c < 0) c = tx_r + MW;
    v = hv(c - 2);
    t = (c + 1 > tx_r + rdy_start) ? c + 1 : tx_r + rdy_start;
    e.cnt    = v;
    e.delta  = W'((int'(v) - int'(model_ref) + (1 << W)) % (1 << W));
    e.wrap   = (v < model_ref);
    e.tmo    = tmo;
    e.cap_e  = c;
    e.xfer_e = t;
    q.push_back(e);
    rj = (rst_at == -2) ? (c - tx_r + 1) : rst_at;
    for (int j = 0; j < L; j++) begin
      if (j > 0) @(negedge clk);
      cnt_in     = plan[j];
      out_ready  = (j >= rdy_start);
      sample_req = (j == 0) || (pokes && j <= t - tx_r && $urandom_range(0, 1) == 1);
      if (j == rj) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_data_outputs", {cnt_valid, cnt_out, delta_out, wrap_flag, timeout_flag}, '0);
        chk("rst_busy", busy, 0);
        q.delete();
        have_cur = 0;
        for (int k = 0; k < 3; k++) h[cyc - k] = '0;
        model_ref = '0;
        sample_req = 1'b0;
        #1 resetn = 1'b1;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    sample_req = 1'b0;
    out_ready  = 1'b0;
    model_ref  = v;
  endtask

  // Monitor: pop the prediction when a snapshot appears, watch it stay frozen,
  // and check the edge at which it is handed over.
  initial begin
    bit pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (cnt_valid && !pv) begin
          if (q.size() == 0) begin
            chk("unexpected_capture", 1, 0);
          end else begin
            cur = q.pop_front();
            have_cur = 1;
            chk("cnt_out", cnt_out, cur.cnt);
            chk("delta_out", delta_out, cur.delta);
            chk("wrap_flag", wrap_flag, cur.wrap);
            chk("timeout_flag", timeout_flag, cur.tmo);
            chk("capture_edge", cyc, cur.cap_e);
            chk("busy_presenting", busy, 1);
          end
        end else if (cnt_valid && have_cur) begin
          chk("frozen_outputs", {cnt_out, delta_out, wrap_flag, timeout_flag},
              {cur.cnt, cur.delta, cur.wrap, cur.tmo});
        end else if (!cnt_valid && pv && have_cur) begin
          chk("transfer_edge", cyc, cur.xfer_e);
          chk("busy_after_transfer", busy, 0);
          have_cur = 0;
        end
      end
      pv = cnt_valid;
    end
  end

  always @(negedge clk) begin
    if (d1_valid && d1_rise < 0) begin
      d1_rise = cyc;
      d1_rise_cnt = d1_cnt;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_r;
    for (int i = 0; i < 8192; i++) h[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_data_outputs", {cnt_valid, cnt_out, delta_out, wrap_flag, timeout_flag}, '0);
    chk("reset_busy", busy, 0);
    resetn = 1'b1;
    cnt_in = 4'h5;
    repeat (4) @(negedge clk);

    first_r = cyc + 1;
    do_txn(0, 4'h5, 4'h0, 0, -1, 0);
    chk("s1_latency", d1_rise, first_r + 1);
    chk("s1_cnt_out", d1_rise_cnt, 4'h5);
    do_txn(0, 4'hE, 4'h0, 0, -1, 0);
    do_txn(0, 4'h3, 4'h0, 0, -1, 0);
    do_txn(1, 4'h7, 4'h8, 0, -1, 0);
    do_txn(4, 4'h9, 4'h0, 14, -1, 1);
    do_txn(0, 4'h6, 4'h0, 0, 1, 0);
    do_txn(0, 4'h2, 4'h0, 0, -1, 0);
    do_txn(0, 4'hB, 4'h0, 12, -2, 0);
    do_txn(0, 4'h4, 4'h0, 0, -1, 0);
    do_txn(0, 4'h4, 4'h0, 3, -1, 0);
    do_txn(0, 4'hF, 4'h0, 0, -1, 0);
    do_txn(0, 4'h0, 4'h0, 0, -1, 0);

    for (int n = 0; n < 40; n++) begin
      int rs;
      rs = -1;
      if ($urandom_range(0, 9) == 0)
        rs = ($urandom_range(0, 1) == 1) ? -2 : int'($urandom_range(1, 3));
      do_txn(int'($urandom_range(0, 4)), W'($urandom), W'($urandom),
             int'($urandom_range(0, 12)), rs, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("end_valid", cnt_valid, 0);
    chk("end_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
